// File: rtl/adc_acq_ctrl.sv
// Acquisition controller for a serial CNV/SCLK/SDO ADC: paces conversions inside each
// adc_en window, accumulates samples and hands one tagged result to readout.
module adc_acq_ctrl #(
    parameter int CLK_DIV       = 4,
    parameter int CONV_CYCLES   = 100,
    parameter int ADC_BITS      = 16,
    parameter int SAMPLE_PERIOD = 1000,
    parameter int ACC_BITS      = 32
) (
    input  logic                fpga_clk,
    input  logic                sys_init_ctrl,
    input  logic                adc_en,
    input  logic [3:0]          rf_sw,
    input  logic [9:0]          rot_count,
    output logic                adc_cnv,
    output logic                adc_sclk,
    input  logic                adc_sdo,
    output logic                res_valid,
    input  logic                res_ready,
    output logic [ACC_BITS-1:0] res_sum,
    output logic [15:0]         res_n,
    output logic [3:0]          res_ch,
    output logic [9:0]          res_rot,
    output logic                overrun,
    output logic [1:0]          o_dbg_state
);

    localparam int PW = (SAMPLE_PERIOD > 1) ? $clog2(SAMPLE_PERIOD) : 1;
    localparam int CW = $clog2(CONV_CYCLES + 1);
    localparam int DW = $clog2(CLK_DIV + 1);
    localparam int BW = $clog2(ADC_BITS + 1);

    localparam logic [PW-1:0] P_LAST    = PW'(SAMPLE_PERIOD - 1);
    localparam logic [CW-1:0] CONV_LAST = CW'(CONV_CYCLES - 1);
    localparam logic [DW-1:0] DIV_LAST  = DW'(CLK_DIV - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(ADC_BITS - 1);

    typedef enum logic [1:0] {S_IDLE, S_CONV, S_READ, S_ACC} state_t;

    state_t                r_state;
    logic                  r_win_open;
    logic                  r_first;
    logic                  r_deliver;
    logic [PW-1:0]         r_pcnt;
    logic [CW-1:0]         r_cnt;
    logic [DW-1:0]         r_div;
    logic [BW-1:0]         r_bit;
    logic [ADC_BITS-1:0]   r_shift;
    logic [ACC_BITS-1:0]   r_sum;
    logic [15:0]           r_n;
    logic [3:0]            r_ch;
    logic [9:0]            r_rot;
    logic                  r_cnv;
    logic                  r_sclk;
    logic                  r_res_valid;
    logic [ACC_BITS-1:0]   r_res_sum;
    logic [15:0]           r_res_n;
    logic [3:0]            r_res_ch;
    logic [9:0]            r_res_rot;
    logic                  r_overrun;
    logic [ACC_BITS:0]     w_sum_ext;

    assign w_sum_ext = {1'b0, r_sum} + (ACC_BITS + 1)'(r_shift);

    // res_valid/res_ready: a result is offered while res_valid=1, its fields are held
    // stable, and it is consumed on any edge where res_valid && res_ready are both high.
    always_ff @(posedge fpga_clk) begin
        if (sys_init_ctrl) begin
            r_state     <= S_IDLE;
            r_win_open  <= 1'b0;
            r_first     <= 1'b0;
            r_deliver   <= 1'b0;
            r_pcnt      <= '0;
            r_cnt       <= '0;
            r_div       <= '0;
            r_bit       <= '0;
            r_shift     <= '0;
            r_sum       <= '0;
            r_n         <= '0;
            r_ch        <= '0;
            r_rot       <= '0;
            r_cnv       <= 1'b0;
            r_sclk      <= 1'b0;
            r_res_valid <= 1'b0;
            r_res_sum   <= '0;
            r_res_n     <= '0;
            r_res_ch    <= '0;
            r_res_rot   <= '0;
            r_overrun   <= 1'b0;
        end else begin
            if (r_res_valid && res_ready) begin
                r_res_valid <= 1'b0;
            end

            r_deliver <= 1'b0;
            if (r_deliver) begin
                if (r_res_valid) begin
                    r_overrun <= 1'b1;
                end else begin
                    r_res_valid <= 1'b1;
                    r_res_sum   <= r_sum;
                    r_res_n     <= r_n;
                    r_res_ch    <= r_ch;
                    r_res_rot   <= r_rot;
                end
            end

            if (r_win_open) begin
                r_pcnt <= (r_pcnt == P_LAST) ? '0 : r_pcnt + 1'b1;
            end

            case (r_state)
                S_IDLE: begin
                    if (!r_win_open) begin
                        if (adc_en) begin
                            r_win_open <= 1'b1;
                            r_first    <= 1'b1;
                            r_ch       <= rf_sw;
                            r_rot      <= rot_count;
                            r_sum      <= '0;
                            r_n        <= '0;
                            r_pcnt     <= '0;
                        end
                    // r_first guarantees the opening sample even for a 1-cycle adc_en pulse
                    end else if (r_pcnt == '0 && (adc_en || r_first)) begin
                        r_state <= S_CONV;
                        r_cnv   <= 1'b1;
                        r_cnt   <= '0;
                        r_first <= 1'b0;
                    end else if (!adc_en) begin
                        r_win_open <= 1'b0;
                        r_deliver  <= 1'b1;
                    end
                end
                S_CONV: begin
                    if (r_cnt == CONV_LAST) begin
                        r_state <= S_READ;
                        r_cnv   <= 1'b0;
                        r_sclk  <= 1'b0;
                        r_div   <= '0;
                        r_bit   <= '0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_READ: begin
                    if (r_div == DIV_LAST) begin
                        r_div <= '0;
                        if (!r_sclk) begin
                            r_sclk  <= 1'b1;
                            r_shift <= {r_shift[ADC_BITS-2:0], adc_sdo};
                        end else begin
                            r_sclk <= 1'b0;
                            if (r_bit == BIT_LAST) begin
                                r_state <= S_ACC;
                            end else begin
                                r_bit <= r_bit + 1'b1;
                            end
                        end
                    end else begin
                        r_div <= r_div + 1'b1;
                    end
                end
                S_ACC: begin
                    r_sum   <= w_sum_ext[ACC_BITS] ? '1 : w_sum_ext[ACC_BITS-1:0];
                    r_n     <= (r_n == 16'hFFFF) ? r_n : r_n + 16'd1;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign adc_cnv     = r_cnv;
    assign adc_sclk    = r_sclk;
    assign res_valid   = r_res_valid;
    assign res_sum     = r_res_sum;
    assign res_n       = r_res_n;
    assign res_ch      = r_res_ch;
    assign res_rot     = r_res_rot;
    assign overrun     = r_overrun;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_adc_acq_ctrl.sv
// Self-checking bench for adc_acq_ctrl: fixed-word ADC model, result scoreboards for a
// 32-bit and a 16-bit accumulator instance, directed window scenarios.
module tb_adc_acq_ctrl;

    localparam int CLK_DIV       = 1;
    localparam int CONV_CYCLES   = 4;
    localparam int ADC_BITS      = 16;
    localparam int SAMPLE_PERIOD = 40;

    logic        fpga_clk = 1'b0;
    logic        sys_init_ctrl = 1'b1;
    logic        adc_en = 1'b0;
    logic        adc_en_s = 1'b0;
    logic [3:0]  rf_sw = 4'd0;
    logic [9:0]  rot_count = 10'd0;
    logic        res_ready = 1'b1;
    logic        adc_sdo;

    logic        adc_cnv, adc_sclk, res_valid, overrun;
    logic [31:0] res_sum;
    logic [15:0] res_n;
    logic [3:0]  res_ch;
    logic [9:0]  res_rot;
    logic [1:0]  dbg_state;

    logic        adc_cnv_s, adc_sclk_s, res_valid_s, overrun_s;
    logic [15:0] res_sum_s;
    logic [15:0] res_n_s;
    logic [3:0]  res_ch_s;
    logic [9:0]  res_rot_s;
    logic [1:0]  dbg_state_s;

    int n_checks = 0;
    int n_fail   = 0;

    logic [61:0] exp_q[$];
    logic [45:0] exp_s_q[$];

    always #5 fpga_clk = ~fpga_clk;

    adc_acq_ctrl #(
        .CLK_DIV(CLK_DIV), .CONV_CYCLES(CONV_CYCLES), .ADC_BITS(ADC_BITS),
        .SAMPLE_PERIOD(SAMPLE_PERIOD), .ACC_BITS(32)
    ) u_dut (
        .fpga_clk(fpga_clk), .sys_init_ctrl(sys_init_ctrl), .adc_en(adc_en),
        .rf_sw(rf_sw), .rot_count(rot_count), .adc_cnv(adc_cnv), .adc_sclk(adc_sclk),
        .adc_sdo(adc_sdo), .res_valid(res_valid), .res_ready(res_ready),
        .res_sum(res_sum), .res_n(res_n), .res_ch(res_ch), .res_rot(res_rot),
        .overrun(overrun), .o_dbg_state(dbg_state)
    );

    adc_acq_ctrl #(
        .CLK_DIV(CLK_DIV), .CONV_CYCLES(CONV_CYCLES), .ADC_BITS(ADC_BITS),
        .SAMPLE_PERIOD(SAMPLE_PERIOD), .ACC_BITS(16)
    ) u_dut_sat (
        .fpga_clk(fpga_clk), .sys_init_ctrl(sys_init_ctrl), .adc_en(adc_en_s),
        .rf_sw(rf_sw), .rot_count(rot_count), .adc_cnv(adc_cnv_s), .adc_sclk(adc_sclk_s),
        .adc_sdo(adc_sdo), .res_valid(res_valid_s), .res_ready(res_ready),
        .res_sum(res_sum_s), .res_n(res_n_s), .res_ch(res_ch_s), .res_rot(res_rot_s),
        .overrun(overrun_s), .o_dbg_state(dbg_state_s)
    );

    // ADC model: MSB presented during CNV, next bit after every SCLK falling edge
    logic [15:0] adc_word = 16'h0000;
    int          bit_idx  = 0;
    logic        cnv_any, sclk_any;
    logic [31:0] bit_idx_v;
    assign cnv_any   = adc_cnv | adc_cnv_s;
    assign sclk_any  = adc_sclk | adc_sclk_s;
    assign bit_idx_v = bit_idx;
    assign adc_sdo   = (bit_idx >= 0) ? adc_word[bit_idx_v[3:0]] : 1'b0;

    always @(posedge cnv_any or negedge sclk_any) begin
        if (cnv_any) bit_idx = ADC_BITS - 1;
        else         bit_idx = bit_idx - 1;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge fpga_clk);
        #1;
    endtask

    task automatic window(input int len);
        adc_en = 1'b1;
        repeat (len) tick();
        adc_en = 1'b0;
    endtask

    // Monitors and scoreboards, sampled on the falling edge
    int   cnv_cycles = 0;
    int   sclk_rises = 0;
    int   valid_cycles = 0;
    logic prev_sclk = 1'b0;

    always @(negedge fpga_clk) begin
        logic [61:0] e;
        logic [45:0] es;
        if (!sys_init_ctrl) begin
            if (adc_cnv) cnv_cycles++;
            if (adc_sclk && !prev_sclk) sclk_rises++;
            if (res_valid) valid_cycles++;
            if (res_valid && res_ready) begin
                if (exp_q.size() == 0) begin
                    chk("res_unexpected", {63'd0, res_valid}, 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("res_sum", {32'd0, res_sum}, {32'd0, e[61:30]});
                    chk("res_n",   {48'd0, res_n},   {48'd0, e[29:14]});
                    chk("res_ch",  {60'd0, res_ch},  {60'd0, e[13:10]});
                    chk("res_rot", {54'd0, res_rot}, {54'd0, e[9:0]});
                end
            end
            if (res_valid_s && res_ready) begin
                if (exp_s_q.size() == 0) begin
                    chk("sat_unexpected", {63'd0, res_valid_s}, 64'd0);
                end else begin
                    es = exp_s_q.pop_front();
                    chk("sat_sum", {48'd0, res_sum_s}, {48'd0, es[45:30]});
                    chk("sat_n",   {48'd0, res_n_s},   {48'd0, es[29:14]});
                    chk("sat_ch",  {60'd0, res_ch_s},  {60'd0, es[13:10]});
                    chk("sat_rot", {54'd0, res_rot_s}, {54'd0, es[9:0]});
                end
            end
        end
        prev_sclk = adc_sclk;
    end

    initial begin
        int cnt;
        bit found;
        logic p_sclk;

        // Reset state
        sys_init_ctrl = 1'b1;
        repeat (3) tick();
        chk("rst_cnv",   {63'd0, adc_cnv},   64'd0);
        chk("rst_sclk",  {63'd0, adc_sclk},  64'd0);
        chk("rst_valid", {63'd0, res_valid}, 64'd0);
        chk("rst_ovr",   {63'd0, overrun},   64'd0);
        chk("rst_sum",   {32'd0, res_sum},   64'd0);
        chk("rst_n",     {48'd0, res_n},     64'd0);
        sys_init_ctrl = 1'b0;
        repeat (2) tick();

        // Nominal window
        adc_word = 16'h1234; rf_sw = 4'b0010; rot_count = 10'd7; res_ready = 1'b1;
        cnv_cycles = 0; sclk_rises = 0; valid_cycles = 0;
        exp_q.push_back({32'h0000_5B04, 16'd5, 4'd2, 10'd7});
        adc_en = 1'b1;
        for (int i = 0; i < 200; i++) begin
            tick();
            if (i == 0) chk("open_cnv_t1", {63'd0, adc_cnv}, 64'd0);
            if (i == 1) chk("open_cnv_t2", {63'd0, adc_cnv}, 64'd1);
        end
        adc_en = 1'b0;
        rf_sw = 4'b1111; rot_count = 10'd99;
        repeat (100) tick();
        chk("nom_cnv_cycles", cnv_cycles, 20);
        chk("nom_sclk_rises", sclk_rises, 80);
        chk("nom_valid_cycles", valid_cycles, 1);
        chk("nom_q_empty", exp_q.size(), 0);

        // Short pulse
        adc_word = 16'hBEEF; rf_sw = 4'b0101; rot_count = 10'd300;
        exp_q.push_back({32'h0000_BEEF, 16'd1, 4'd5, 10'd300});
        window(1);
        repeat (100) tick();
        chk("pulse_q_empty", exp_q.size(), 0);

        // Saturation on the 16-bit accumulator instance
        adc_word = 16'hFFFF; rf_sw = 4'b1000; rot_count = 10'd1023;
        exp_s_q.push_back({16'hFFFF, 16'd2, 4'd8, 10'd1023});
        adc_en_s = 1'b1;
        repeat (60) tick();
        adc_en_s = 1'b0;
        repeat (100) tick();
        chk("sat_q_empty", exp_s_q.size(), 0);

        // Backpressure and overrun
        res_ready = 1'b0;
        adc_word = 16'h1111; rf_sw = 4'b0011; rot_count = 10'd42;
        exp_q.push_back({32'h0000_2222, 16'd2, 4'd3, 10'd42});
        window(50);
        repeat (100) tick();
        chk("bp_valid1", {63'd0, res_valid}, 64'd1);
        chk("bp_ovr1",   {63'd0, overrun},   64'd0);
        adc_word = 16'h2222; rf_sw = 4'b0110; rot_count = 10'd43;
        window(50);
        repeat (100) tick();
        chk("bp_ovr2",   {63'd0, overrun},   64'd1);
        chk("bp_held_sum", {32'd0, res_sum}, 64'h2222);
        chk("bp_held_ch",  {60'd0, res_ch},  64'd3);
        res_ready = 1'b1;
        tick();
        chk("bp_valid_drop", {63'd0, res_valid}, 64'd0);
        chk("bp_ovr_sticky", {63'd0, overrun},   64'd1);
        chk("bp_q_empty", exp_q.size(), 0);
        repeat (5) tick();

        // Reset during READ, on bit 8 of the first sample
        adc_word = 16'h0101; rf_sw = 4'b1001; rot_count = 10'd513;
        adc_en = 1'b1;
        cnt = 0; found = 1'b0; p_sclk = adc_sclk;
        for (int i = 0; i < 200 && !found; i++) begin
            tick();
            if (adc_sclk && !p_sclk) cnt++;
            p_sclk = adc_sclk;
            if (cnt == 8) found = 1'b1;
        end
        chk("rst_read_reached", {63'd0, found}, 64'd1);
        sys_init_ctrl = 1'b1;
        adc_en = 1'b0;
        tick();
        chk("mid_rst_cnv",   {63'd0, adc_cnv},   64'd0);
        chk("mid_rst_sclk",  {63'd0, adc_sclk},  64'd0);
        chk("mid_rst_valid", {63'd0, res_valid}, 64'd0);
        chk("mid_rst_ovr",   {63'd0, overrun},   64'd0);
        sys_init_ctrl = 1'b0;
        valid_cycles = 0;
        repeat (100) tick();
        chk("aborted_no_result", valid_cycles, 0);
        exp_q.push_back({32'h0000_0303, 16'd3, 4'd9, 10'd513});
        window(100);
        repeat (100) tick();
        chk("post_rst_q_empty", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/adc_acq_ctrl.md
# adc_acq_ctrl

Acquisition controller for the radiometer ADC. It runs during each `adc_en` measurement window from the measurement sequencer. It paces conversions of a serial (CNV/SCLK/SDO) ADC at a fixed rate and accumulates the samples. At window close it presents one tagged result (sum, sample count, RF channel, rotation index) to readout over a valid/ready handshake.

## Interface
Parameters:
- `CLK_DIV`, 4: SCLK half-period in `fpga_clk` cycles (≥1).
- `CONV_CYCLES`, 100: CNV high time in cycles (≥1).
- `ADC_BITS`, 16: bits per sample, MSB first.
- `SAMPLE_PERIOD`, 1000: conversion start-to-start spacing in cycles. Must be ≥ `CONV_CYCLES + 2*CLK_DIV*ADC_BITS + 2`.
- `ACC_BITS`, 32: accumulator width (≥ `ADC_BITS`).

Ports:
- `fpga_clk`  in  1  system clock; sole clock domain.
- `sys_init_ctrl`  in  1  reset. Synchronous, active-high.
- `adc_en`  in  1  measurement window level from sequencer.
- `rf_sw`  in  4  current RF switch selection.
- `rot_count`  in  10  current rotation index.
- `adc_cnv`  out  1  ADC conversion start; high = converting.
- `adc_sclk`  out  1  ADC serial clock; idles low.
- `adc_sdo`  in  1  ADC serial data; already synchronous to `fpga_clk`.
- `res_valid`  out  1  result available.
- `res_ready`  in  1  readout accepts result.
- `res_sum`  out  `ACC_BITS`  saturating sum of samples.
- `res_n`  out  16  sample count, saturating at 65535.
- `res_ch`  out  4  `rf_sw` latched at window open.
- `res_rot`  out  10  `rot_count` latched at window open.
- `overrun`  out  1  sticky: a result was dropped.

## Operation
- FSM states: IDLE, CONV, READ, ACC.
- `win_open` flag; period counter `pcnt` (0..`SAMPLE_PERIOD`-1).
- Window open:
  - Condition: IDLE, `!win_open`, `adc_en`=1.
  - Actions: set `win_open`; latch `rf_sw` and `rot_count`; clear sum and n; `pcnt`=0.
- Sampling while `win_open`:
  - `pcnt` increments each cycle and wraps to 0 after `SAMPLE_PERIOD`-1.
  - A conversion starts when IDLE, `pcnt`==0 and `adc_en`=1. This includes the cycle right after open.
- CONV: `adc_cnv`=1 for exactly `CONV_CYCLES` cycles, then READ.
- READ, per bit:
  - `adc_sclk` low for `CLK_DIV` cycles, then high for `CLK_DIV` cycles.
  - `adc_sdo` is shifted in on the clock edge where `adc_sclk` goes 0→1.
  - After `ADC_BITS` bits, `adc_sclk` returns low and the FSM goes to ACC.
- ACC (1 cycle):
  - `sum <= min(sum + sample, 2^ACC_BITS-1)` (unsigned).
  - `n <= min(n+1, 65535)`.
  - Then IDLE.
- Window close:
  - Condition: IDLE, `win_open`, `adc_en`=0.
  - A conversion in flight when `adc_en` falls completes and is accumulated first.
  - Action: clear `win_open`, then deliver the result.
- Result delivery:
  - If `res_valid`=0: load `res_*` and set `res_valid`.
  - If `res_valid`=1 (previous result not yet accepted): drop the new result, keep the old one, set `overrun`.
- Handshake:
  - `res_valid` clears on the cycle after `res_valid && res_ready`.
  - `res_*` are stable while `res_valid`=1.
- A new window may open in the cycle after close, independent of `res_valid`.
- Reset:
  - All outputs go to 0 on the next edge: `adc_cnv`, `adc_sclk`, `res_valid`, `res_sum`, `res_n`, `res_ch`, `res_rot`, `overrun`.
  - FSM goes to IDLE, `win_open`=0, counters clear.
  - A partial window is discarded.
  - Reset has priority over every other event.

## Timing
- Window open: `adc_en` sampled high in cycle t → `win_open` at t+1. First `adc_cnv`=1 at t+2.
- Busy time per sample: `CONV_CYCLES + 2*CLK_DIV*ADC_BITS + 1` cycles (CONV + READ + ACC).
- Samples per window:
  - Equals the number of `pcnt`==0 instants while `adc_en`=1 and `win_open`.
  - A 1-cycle `adc_en` pulse yields exactly 1 sample.
- Result latency: `res_valid` rises 2 cycles after the FSM returns to IDLE with `adc_en`=0 (1 cycle close, 1 cycle load).
- `res_ready` may be held high permanently. A result then lasts exactly one cycle.
- `adc_sdo` is captured in the cycle before the `adc_sclk` rising edge. The ADC must drive data by the preceding `adc_sclk` falling edge.

## Test plan
Bench parameters: `CLK_DIV`=1, `CONV_CYCLES`=4, `ADC_BITS`=16, `SAMPLE_PERIOD`=40, `ACC_BITS`=32. ADC model returns a fixed word.

- **Nominal window:** ADC word 0x1234; `rf_sw`=4'b0010, `rot_count`=7; `adc_en` high 200 cycles, `res_ready`=1 → one `res_valid` pulse with `res_sum`=0x5B04, `res_n`=5, `res_ch`=2, `res_rot`=7. Each sample shows `adc_cnv` high 4 cycles, then 16 `adc_sclk` pulses.
- **Short pulse:** 1-cycle `adc_en` with word 0xBEEF → `res_n`=1, `res_sum`=0xBEEF. The in-flight sample completes after `adc_en` falls.
- **Saturation:** `ACC_BITS`=16, word 0xFFFF, `adc_en` high 60 cycles → `res_n`=2, `res_sum`=0xFFFF.
- **Backpressure/overrun:** `res_ready`=0; two windows of 50 cycles each → first result held unchanged, `overrun`=1 after the second close. Then raise `res_ready` → `res_valid` drops next cycle; `overrun` stays 1 until reset.
- **Reset mid-READ:** assert `sys_init_ctrl` on bit 8 of a sample → next cycle `adc_cnv`=0, `adc_sclk`=0, `res_valid`=0, `overrun`=0. No result is emitted for the aborted window. A following 100-cycle window reports `res_n`=3.
